lane_scroll_ctrl: RTL and testbench

Controller for the road's centre-line dash sprites in the racing display. It runs a per-frame speed state machine and advances a vertical scroll offset once per frame. From the offset it produces position and enable for NUM_DASH centre-line sprite instances, so the dashes appear to stream down the screen. Optionally it merges the instances' pixel outputs into one prioritised colour/data stream for the VGA mixer.

---
 rtl/lane_pkg.sv | 34 +++
 rtl/lane_pixel_merge.sv | 49 ++++
 rtl/lane_scroll_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lane_scroll_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// lane_pkg: shared widths, default geometry, FSM state enum and colour payload
// for the centre-line dash scroller (lane_scroll_ctrl, lane_pixel_merge).
package lane_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned SPEED_W = 4;
    localparam int unsigned OFFS_W  = 8;
    localparam int unsigned RED_W   = 3;
    localparam int unsigned GRN_W   = 3;
    localparam int unsigned BLU_W   = 2;

    localparam int unsigned DEF_NUM_DASH  = 4;
    localparam int unsigned DEF_PITCH     = 135;
    localparam int unsigned DEF_DASH_H    = 60;
    localparam int unsigned DEF_SCREEN_H  = 480;
    localparam int unsigned DEF_POSX      = 307;
    localparam int unsigned DEF_MAX_SPEED = 8;
    localparam int unsigned DEF_ACCEL_DIV = 4;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        ACCEL   = 2'd1,
        CRUISE  = 2'd2,
        DECEL   = 2'd3
    } lane_state_e;

    typedef struct packed {
        logic [RED_W-1:0] red;
        logic [GRN_W-1:0] green;
        logic [BLU_W-1:0] blue;
    } lane_rgb_t;

endpackage

// File: rtl/lane_pixel_merge.sv
// lane_pixel_merge: registered priority mux over the dash sprite pixel outputs.
// Lowest index with an opaque pixel wins; colour holds when no pixel is opaque.
module lane_pixel_merge
    import lane_pkg::*;
#(
    parameter int unsigned NUM_DASH = DEF_NUM_DASH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_DASH-1:0]         dash_data,
    input  logic [COLOR_W*NUM_DASH-1:0] dash_rgb,
    output logic [RED_W-1:0]            red,
    output logic [GRN_W-1:0]            green,
    output logic [BLU_W-1:0]            blue,
    output logic                        data
);

    lane_rgb_t rgb_q, rgb_d;
    logic      data_q, data_d;

    // Priority select: scan from the highest index so the lowest one overrides
    always_comb begin
        rgb_d  = rgb_q;
        data_d = 1'b0;
        for (int i = NUM_DASH - 1; i >= 0; i--) begin
            if (dash_data[i]) begin
                rgb_d  = lane_rgb_t'(dash_rgb[i*COLOR_W +: COLOR_W]);
                data_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rgb_q  <= '0;
            data_q <= 1'b0;
        end else begin
            rgb_q  <= rgb_d;
            data_q <= data_d;
        end
    end

    assign red   = rgb_q.red;
    assign green = rgb_q.green;
    assign blue  = rgb_q.blue;
    assign data  = data_q;

endmodule

// File: rtl/lane_scroll_ctrl.sv
// lane_scroll_ctrl: per-frame speed FSM and vertical scroll of the road's
// centre-line dash sprites. Optional pixel merge enabled by LANE_PIXEL_MERGE_EN.
module lane_scroll_ctrl
    import lane_pkg::*;
#(
    parameter int unsigned NUM_DASH  = DEF_NUM_DASH,
    parameter int unsigned PITCH     = DEF_PITCH,
    parameter int unsigned DASH_H    = DEF_DASH_H,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned POSX      = DEF_POSX,
    parameter int unsigned MAX_SPEED = DEF_MAX_SPEED,
    parameter int unsigned ACCEL_DIV = DEF_ACCEL_DIV
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [COORD_W-1:0]          hcount,
    input  logic [COORD_W-1:0]          vcount,
    input  logic                        run,
    input  logic                        brake,
    output logic [COORD_W-1:0]          posx,
    output logic [COORD_W*NUM_DASH-1:0] posy_bus,
    output logic [NUM_DASH-1:0]         enable_bus,
    output logic [SPEED_W-1:0]          speed,
    output logic                        frame_tick,
    input  logic [NUM_DASH-1:0]         dash_data,
    input  logic [COLOR_W*NUM_DASH-1:0] dash_rgb,
    output logic [RED_W-1:0]            red,
    output logic [GRN_W-1:0]            green,
    output logic [BLU_W-1:0]            blue,
    output logic                        data
);

    localparam int unsigned DIV_W = $clog2(ACCEL_DIV + 1);
    localparam int unsigned SUM_W = OFFS_W + 1;

    localparam logic [1:0] ST_STOPPED = 2'(STOPPED);
    localparam logic [1:0] ST_ACCEL   = 2'(ACCEL);
    localparam logic [1:0] ST_CRUISE  = 2'(CRUISE);
    localparam logic [1:0] ST_DECEL   = 2'(DECEL);

    localparam logic [SPEED_W-1:0] MAX_SPD = SPEED_W'(MAX_SPEED);

    // Dashes must cover the screen plus one sprite height so scrolling leaves no gap
    if ((NUM_DASH * PITCH < SCREEN_H + DASH_H) || (MAX_SPEED > 15) || (ACCEL_DIV == 0)) begin : g_bad_cfg
        $error("lane_scroll_ctrl: invalid dash geometry or speed configuration");
    end

    logic                frame_tick_q;
    logic [1:0]          state_q, state_d, mode;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [DIV_W-1:0]    div_q, div_d, div_base, div_inc;
    logic                div_wrap;
    logic [OFFS_W-1:0]   offset_q, offset_d;
    logic [SUM_W-1:0]    offs_sum;
    logic [COORD_W-1:0]  posy_q [NUM_DASH];
    logic [COORD_W-1:0]  posy_d [NUM_DASH];
    logic [NUM_DASH-1:0] enable_q, enable_d;

    // Frame tick: registered end-of-visible-area condition
    always_ff @(posedge clock) begin
        if (!reset_n) frame_tick_q <= 1'b0;
        else          frame_tick_q <= (hcount == '0) && (vcount == COORD_W'(SCREEN_H));
    end

    // Speed FSM next state; the transition tick already acts in the new mode
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        div_d    = div_q;
        mode     = state_q;
        div_base = '0;
        div_inc  = '0;
        div_wrap = 1'b0;
        if (frame_tick_q) begin
            if (brake || !run) mode = (speed_q == '0) ? ST_STOPPED : ST_DECEL;
            else               mode = (speed_q == MAX_SPD) ? ST_CRUISE : ST_ACCEL;
            div_base = (mode == state_q) ? div_q : '0;
            div_inc  = div_base + DIV_W'(1);
            div_wrap = (div_inc == DIV_W'(ACCEL_DIV));
            state_d  = mode;
            div_d    = '0;
            case (mode)
                ST_ACCEL: begin
                    if (div_wrap) speed_d = (speed_q < MAX_SPD) ? speed_q + SPEED_W'(1) : speed_q;
                    else          div_d   = div_inc;
                    if (speed_d == MAX_SPD) begin
                        state_d = ST_CRUISE;
                        div_d   = '0;
                    end
                end
                ST_DECEL: begin
                    if (brake || div_wrap) speed_d = (speed_q != '0) ? speed_q - SPEED_W'(1) : '0;
                    else                   div_d   = div_inc;
                    if (speed_d == '0) begin
                        state_d = ST_STOPPED;
                        div_d   = '0;
                    end
                end
                ST_STOPPED: speed_d = '0;
                default: ;
            endcase
        end
    end

    // Scroll offset advances by the pre-update speed, wrapped at one pitch
    always_comb begin
        offs_sum = {1'b0, offset_q} + SUM_W'(speed_q);
        offset_d = offset_q;
        if (frame_tick_q) begin
            offset_d = (offs_sum >= SUM_W'(PITCH)) ? OFFS_W'(offs_sum - SUM_W'(PITCH))
                                                   : OFFS_W'(offs_sum);
        end
    end

    // Dash positions and visibility from the next offset
    always_comb begin
        for (int i = 0; i < NUM_DASH; i++) begin
            posy_d[i]   = COORD_W'(i * PITCH) + COORD_W'(offset_d);
            enable_d[i] = (posy_d[i] < COORD_W'(SCREEN_H));
        end
    end

    // State, speed, offset and sprite position registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_STOPPED;
            speed_q  <= '0;
            div_q    <= '0;
            offset_q <= '0;
            for (int i = 0; i < NUM_DASH; i++) begin
                posy_q[i]   <= COORD_W'(i * PITCH);
                enable_q[i] <= (i * PITCH < SCREEN_H);
            end
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            div_q    <= div_d;
            offset_q <= offset_d;
            posy_q   <= posy_d;
            enable_q <= enable_d;
        end
    end

    // Flatten dash positions onto the bus
    always_comb begin
        posy_bus = '0;
        for (int i = 0; i < NUM_DASH; i++) begin
            posy_bus[i*COORD_W +: COORD_W] = posy_q[i];
        end
    end

    assign posx       = COORD_W'(POSX);
    assign enable_bus = enable_q;
    assign speed      = speed_q;
    assign frame_tick = frame_tick_q;

`ifdef LANE_PIXEL_MERGE_EN
    lane_pixel_merge #(
        .NUM_DASH (NUM_DASH)
    ) u_merge (
        .clock     (clock),
        .reset_n   (reset_n),
        .dash_data (dash_data),
        .dash_rgb  (dash_rgb),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .data      (data)
    );
`else
    // Instances are OR-ed by the mixer; sprite pixel inputs are not consumed here
    logic unused_pix;
    assign unused_pix = ^{dash_data, dash_rgb};
    assign red   = '0;
    assign green = '0;
    assign blue  = '0;
    assign data  = 1'b0;
`endif

endmodule

// File: tb/tb_lane_scroll_ctrl.sv
// tb_lane_scroll_ctrl: table vectors, hand sequences and randomized frames for
// lane_scroll_ctrl, compared against a frame-level behavioural model.
module tb_lane_scroll_ctrl;
    import lane_pkg::*;

    localparam int PITCH    = 135;
    localparam int SCREEN_H = 480;
    localparam int POSX     = 307;
    localparam int MAXS     = 8;
    localparam int DIV      = 4;

    localparam int MD_STOP   = 0;
    localparam int MD_UP     = 1;
    localparam int MD_CRUISE = 2;
    localparam int MD_DOWN   = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hcount = 10'd5;
    logic [9:0]  vcount = 10'd100;
    logic        run = 1'b0;
    logic        brake = 1'b0;
    logic [9:0]  posx;
    logic [39:0] posy_bus;
    logic [3:0]  enable_bus;
    logic [3:0]  speed;
    logic        frame_tick;
    logic [3:0]  dash_data = 4'd0;
    logic [31:0] dash_rgb = 32'd0;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        data;

    always #5 clock = ~clock;

    lane_scroll_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .run        (run),
        .brake      (brake),
        .posx       (posx),
        .posy_bus   (posy_bus),
        .enable_bus (enable_bus),
        .speed      (speed),
        .frame_tick (frame_tick),
        .dash_data  (dash_data),
        .dash_rgb   (dash_rgb),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .data       (data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference model
    int         m_speed, m_offset, m_mode, m_ticks;
    logic [7:0] m_rgb;
    logic       m_data;

    typedef struct {
        logic r;
        logic b;
        int   spd;
        int   py0;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] exp_posy(input int off);
        logic [39:0] v;
        for (int i = 0; i < 4; i++) v[i*10 +: 10] = 10'(i * PITCH + off);
        return v;
    endfunction

    function automatic logic [3:0] exp_en(input int off);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = ((i * PITCH + off) < SCREEN_H);
        return v;
    endfunction

    task automatic model_reset();
        m_speed = 0; m_offset = 0; m_mode = MD_STOP; m_ticks = 0;
        m_rgb = 8'd0; m_data = 1'b0;
    endtask

    // One frame of the speed rules: count ticks spent in the current mode
    task automatic model_tick(input logic r, input logic b);
        int old_speed;
        int nm;
        old_speed = m_speed;
        if (b || !r) nm = (m_speed == 0) ? MD_STOP : MD_DOWN;
        else         nm = (m_speed == MAXS) ? MD_CRUISE : MD_UP;
        if (nm != m_mode) m_ticks = 0;
        m_mode = nm;
        m_ticks++;
        if (nm == MD_UP && (m_ticks % DIV) == 0) m_speed++;
        if (nm == MD_DOWN) begin
            if (b) begin
                m_speed--;
                m_ticks = 0;
            end else if ((m_ticks % DIV) == 0) begin
                m_speed--;
            end
        end
        if (m_mode == MD_UP && m_speed == MAXS) begin m_mode = MD_CRUISE; m_ticks = 0; end
        if (m_mode == MD_DOWN && m_speed == 0)  begin m_mode = MD_STOP;   m_ticks = 0; end
        m_offset = (m_offset + old_speed) % PITCH;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_speed"}, 64'(speed), 64'(m_speed));
        check({tag, "_posy"}, 64'(posy_bus), 64'(exp_posy(m_offset)));
        check({tag, "_enable"}, 64'(enable_bus), 64'(exp_en(m_offset)));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; dash_data = 4'd0; hcount = 10'd5; vcount = 10'd100;
        @(negedge clock);
        model_reset();
        check("rst_posy", 64'(posy_bus), 64'({10'd405, 10'd270, 10'd135, 10'd0}));
        check("rst_enable", 64'(enable_bus), 64'(4'b1111));
        check("rst_speed", 64'(speed), 64'd0);
        check("rst_tick", 64'(frame_tick), 64'd0);
        check("rst_posx", 64'(posx), 64'(POSX));
        check("rst_data", 64'(data), 64'd0);
        check("rst_rgb", 64'({red, green, blue}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One frame tick with run/brake held across the sampling cycle
    task automatic frame(input logic r, input logic b);
        @(negedge clock);
        run = r; brake = b; hcount = 10'd0; vcount = 10'(SCREEN_H);
        @(negedge clock);
        hcount = 10'd5; vcount = 10'd100;
        check("tick_hi", 64'(frame_tick), 64'd1);
        @(negedge clock);
        check("tick_lo", 64'(frame_tick), 64'd0);
        model_tick(r, b);
        check_outputs("frame");
        run = 1'($urandom); brake = 1'($urandom);
        repeat (2) @(negedge clock);
        check_outputs("hold");
    endtask

    task automatic merge_step(input logic [3:0] dd, input logic [31:0] rgb);
        @(negedge clock);
        dash_data = dd; dash_rgb = rgb;
`ifdef LANE_PIXEL_MERGE_EN
        m_data = (dd != 4'd0);
        for (int i = 3; i >= 0; i--) if (dd[i]) m_rgb = rgb[i*8 +: 8];
`endif
        @(negedge clock);
        check("merge_data", 64'(data), 64'(m_data));
        check("merge_rgb", 64'({red, green, blue}), 64'(m_rgb));
    endtask

    initial begin
        vec_t va[5];
        vec_t vb[15];
        logic r, b;
        logic [2:0] exp_red;
        logic       exp_data;

        va[0] = '{r: 1'b1, b: 1'b0, spd: 0, py0: 0};
        va[1] = '{r: 1'b1, b: 1'b0, spd: 0, py0: 0};
        va[2] = '{r: 1'b1, b: 1'b0, spd: 0, py0: 0};
        va[3] = '{r: 1'b1, b: 1'b0, spd: 1, py0: 0};
        va[4] = '{r: 1'b1, b: 1'b0, spd: 1, py0: 1};
        for (int i = 0; i < 8; i++) vb[i] = '{r: 1'b1, b: 1'b1, spd: 7 - i, py0: -1};
        vb[7].r = 1'b0;
        for (int i = 8; i < 11; i++) vb[i] = '{r: 1'b1, b: 1'b1, spd: 0, py0: -1};
        for (int i = 11; i < 15; i++) vb[i] = '{r: 1'b1, b: 1'b0, spd: (i == 14) ? 1 : 0, py0: -1};

        do_reset();

        // Acceleration from standstill
        for (int i = 0; i < 5; i++) begin
            frame(va[i].r, va[i].b);
            check($sformatf("vecA%0d_speed", i), 64'(speed), 64'(va[i].spd));
            check($sformatf("vecA%0d_posy0", i), 64'(posy_bus[9:0]), 64'(va[i].py0));
        end
        check("tick5_posy", 64'(posy_bus), 64'({10'd406, 10'd271, 10'd136, 10'd1}));

        // Reach cruise, then line up the offset wrap cases
        for (int g = 0; g < 60 && m_speed != MAXS; g++) frame(1'b1, 1'b0);
        check("reach_cruise", 64'(speed), 64'(MAXS));
        for (int g = 0; g < 200 && m_offset != 130; g++) frame(1'b1, 1'b0);
        check("reach_off130", 64'(m_offset), 64'd130);
        frame(1'b1, 1'b0);
        check("wrap_posy", 64'(posy_bus), 64'({10'd408, 10'd273, 10'd138, 10'd3}));
        for (int g = 0; g < 200 && m_offset != 80; g++) frame(1'b1, 1'b0);
        check("reach_off80", 64'(m_offset), 64'd80);
        check("off80_enable", 64'(enable_bus), 64'(4'b0111));
        check("off80_posy3", 64'(posy_bus[39:30]), 64'd485);

        // Braking from cruise, then run+brake must not accelerate
        for (int i = 0; i < 15; i++) begin
            frame(vb[i].r, vb[i].b);
            check($sformatf("vecB%0d_speed", i), 64'(speed), 64'(vb[i].spd));
        end

        // Pixel merge
`ifdef LANE_PIXEL_MERGE_EN
        exp_red = 3'd7; exp_data = 1'b1;
`else
        exp_red = 3'd0; exp_data = 1'b0;
`endif
        merge_step(4'b0110, 32'h001C_E000);
        check("merge_hand_red", 64'(red), 64'(exp_red));
        check("merge_hand_gb", 64'({green, blue}), 64'd0);
        check("merge_hand_data", 64'(data), 64'(exp_data));
        merge_step(4'b0000, 32'hFFFF_FFFF);
        check("merge_idle_data", 64'(data), 64'd0);
        check("merge_idle_red", 64'(red), 64'(exp_red));

        // Randomized frames and pixels
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 4) == 0);
            frame(r, b);
            merge_step(4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
